// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for the 5-stage core: turns hazard flags into per-stage
// controls, holds fetch redirects across i-mem busy cycles, and tracks stall statistics.
module pipeline_stall_controller #(
    parameter int CORE         = 0,
    parameter int COUNTER_BITS = 32,
    parameter int DMEM_TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_mem_hazard,
    input  logic                    d_mem_hazard,
    input  logic                    JALR_branch_hazard,
    input  logic                    JAL_hazard,
    output logic                    stall_fetch,
    output logic                    stall_decode,
    output logic                    stall_execute,
    output logic                    stall_memory,
    output logic                    flush_decode,
    output logic                    flush_execute,
    output logic                    bubble_writeback,
    output logic                    redirect_hold,
    output logic                    dmem_timeout,
    output logic [COUNTER_BITS-1:0] stall_cycles,
    output logic [COUNTER_BITS-1:0] flush_events
);

    localparam int RUN_W = (DMEM_TIMEOUT > 0) ? $clog2(DMEM_TIMEOUT + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DMEM_TIMEOUT);

    if (COUNTER_BITS < 1 || DMEM_TIMEOUT < 0 || CORE < 0) begin : g_param_check
        $error("pipeline_stall_controller: illegal parameter value");
    end

    typedef enum logic [1:0] {
        RUN,
        DSTALL,
        REDIRECT_WAIT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_dh;
    logic                    w_br;
    logic                    w_jl;
    logic [COUNTER_BITS-1:0] r_stall_cycles;
    logic [COUNTER_BITS-1:0] r_flush_events;
    logic [RUN_W-1:0]        r_run;
    logic                    r_timeout;

    // The data-memory hazard masks both control-flow hazards; JALR/branch masks JAL.
    assign w_dh = d_mem_hazard;
    assign w_br = JALR_branch_hazard & ~w_dh;
    assign w_jl = JAL_hazard & ~w_dh & ~JALR_branch_hazard;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of process evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next     = r_state;
        stall_fetch      = w_dh | i_mem_hazard;
        stall_decode     = w_dh;
        stall_execute    = w_dh;
        stall_memory     = w_dh;
        bubble_writeback = w_dh;
        flush_execute    = w_br;
        redirect_hold    = 1'b0;
        flush_decode     = w_br | w_jl | (i_mem_hazard & ~w_dh);

        case (r_state)
            REDIRECT_WAIT: begin
                redirect_hold = 1'b1;
                flush_decode  = 1'b1;
                if (!i_mem_hazard && !w_dh) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                // RUN and DSTALL share the same transition rules.
                if (w_dh) begin
                    w_state_next = DSTALL;
                end else if ((w_br | w_jl) && i_mem_hazard) begin
                    w_state_next = REDIRECT_WAIT;
                end else begin
                    w_state_next = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (stall_fetch && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + COUNTER_BITS'(1);
            end
            if ((w_br | w_jl) && r_flush_events != '1) begin
                r_flush_events <= r_flush_events + COUNTER_BITS'(1);
            end
        end
    end

    // The run counter saturates at the limit; the flag latches on the edge that reaches it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_dh) begin
                r_run <= '0;
            end else if (r_run != RUN_MAX) begin
                r_run <= r_run + RUN_W'(1);
            end
            if (DMEM_TIMEOUT != 0 && w_dh && r_run == RUN_MAX - RUN_W'(1)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
    assign dmem_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: a default-parameter instance and a small one (3-bit counters, timeout 4)
// share stimulus; directed vectors push hand-computed expectations, a monitor checks each cycle.
module tb_pipeline_stall_controller;

    // Control bit order: {sf, sd, se, sm, fd, fe, bw, rh, timeout}
    localparam logic [8:0] C_IDLE  = 9'b000000000;
    localparam logic [8:0] C_DST   = 9'b111100100;
    localparam logic [8:0] C_IM    = 9'b100010000;
    localparam logic [8:0] C_BR    = 9'b000011000;
    localparam logic [8:0] C_BRIM  = 9'b100011000;
    localparam logic [8:0] C_JL    = 9'b000010000;
    localparam logic [8:0] C_RW    = 9'b000010010;
    localparam logic [8:0] C_RW_IM = 9'b100010010;
    localparam logic [8:0] C_RW_DH = 9'b111110110;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic imh   = 1'b0;
    logic dmh   = 1'b0;
    logic jalr  = 1'b0;
    logic jal   = 1'b0;

    logic        m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_bw, m_rh, m_to;
    logic [31:0] m_sc, m_fev;
    logic        s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_bw, s_rh, s_to;
    logic [2:0]  s_sc, s_fev;

    always #5 clock = ~clock;

    pipeline_stall_controller u_dut (
        .clock              (clock),
        .reset              (reset),
        .i_mem_hazard       (imh),
        .d_mem_hazard       (dmh),
        .JALR_branch_hazard (jalr),
        .JAL_hazard         (jal),
        .stall_fetch        (m_sf),
        .stall_decode       (m_sd),
        .stall_execute      (m_se),
        .stall_memory       (m_sm),
        .flush_decode       (m_fd),
        .flush_execute      (m_fe),
        .bubble_writeback   (m_bw),
        .redirect_hold      (m_rh),
        .dmem_timeout       (m_to),
        .stall_cycles       (m_sc),
        .flush_events       (m_fev)
    );

    pipeline_stall_controller #(
        .CORE         (1),
        .COUNTER_BITS (3),
        .DMEM_TIMEOUT (4)
    ) u_small (
        .clock              (clock),
        .reset              (reset),
        .i_mem_hazard       (imh),
        .d_mem_hazard       (dmh),
        .JALR_branch_hazard (jalr),
        .JAL_hazard         (jal),
        .stall_fetch        (s_sf),
        .stall_decode       (s_sd),
        .stall_execute      (s_se),
        .stall_memory       (s_sm),
        .flush_decode       (s_fd),
        .flush_execute      (s_fe),
        .bubble_writeback   (s_bw),
        .redirect_hold      (s_rh),
        .dmem_timeout       (s_to),
        .stall_cycles       (s_sc),
        .flush_events       (s_fev)
    );

    typedef struct {
        string      name;
        logic [8:0] ctl;
        int         sc;
        int         fe;
        int         ssc;
        logic       sto;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic vld    = 1'b0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    task automatic check(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h", name, what, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [8:0] ctl, input int sc,
                        input int fe, input int ssc, input logic sto);
        exp_t x;
        x.name = name;
        x.ctl  = ctl;
        x.sc   = sc;
        x.fe   = fe;
        x.ssc  = ssc;
        x.sto  = sto;
        q.push_back(x);
    endtask

    // One vector per cycle: drive just after the rising edge, expectation reflects prior edges.
    task automatic v(input string name, input logic i, input logic d, input logic b,
                     input logic j, input logic [8:0] ctl, input int sc, input int fe,
                     input int ssc, input logic sto);
        @(posedge clock);
        #1;
        reset = 1'b1;
        imh   = i;
        dmh   = d;
        jalr  = b;
        jal   = j;
        push(name, ctl, sc, fe, ssc, sto);
        vld = 1'b1;
    endtask

    // Reset asserted mid-cycle; the following falling edge shows whether it acted at once.
    task automatic rst(input string name);
        @(posedge clock);
        #1;
        reset = 1'b0;
        imh   = 1'b0;
        dmh   = 1'b0;
        jalr  = 1'b0;
        jal   = 1'b0;
        push(name, C_IDLE, 0, 0, 0, 1'b0);
        vld = 1'b1;
    endtask

    always @(negedge clock) begin
        if (vld) begin
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard: got empty queue expected an entry");
            end else begin
                e = q.pop_front();
                n_vec++;
                check(e.name, "ctl", 32'({m_sf, m_sd, m_se, m_sm, m_fd, m_fe, m_bw, m_rh, m_to}),
                      32'(e.ctl));
                check(e.name, "stall_cycles", m_sc, e.sc);
                check(e.name, "flush_events", m_fev, e.fe);
                check(e.name, "small_ctl",
                      32'({s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_bw, s_rh, s_to}),
                      32'({e.ctl[8:1], e.sto}));
                check(e.name, "small_stall_cycles", 32'(s_sc), e.ssc);
                check(e.name, "small_flush_events", 32'(s_fev), e.fe);
            end
        end
    end

    initial begin
        // Reset then idle
        rst("reset");
        for (int i = 0; i < 10; i++) v("idle", 0, 0, 0, 0, C_IDLE, 0, 0, 0, 1'b0);

        // Data stall for 5 cycles; the small instance's watchdog trips on the 4th edge
        rst("reset2");
        for (int i = 0; i < 5; i++) v("dstall", 0, 1, 0, 0, C_DST, i, 0, i, (i == 4));
        v("dstall_end", 0, 0, 0, 0, C_IDLE, 5, 0, 5, 1'b1);
        v("after_dstall_jal", 0, 0, 0, 1, C_JL, 5, 0, 5, 1'b1);
        v("after_jal", 0, 0, 0, 0, C_IDLE, 5, 1, 5, 1'b1);

        // Redirect while instruction memory is busy
        rst("reset3");
        v("br_imem", 1, 0, 1, 0, C_BRIM, 0, 0, 0, 1'b0);
        for (int i = 1; i < 4; i++) v("redirect_wait", 1, 0, 0, 0, C_RW_IM, i, 1, i, 1'b0);
        v("redirect_exit", 0, 0, 0, 0, C_RW, 4, 1, 4, 1'b0);
        v("redirect_done", 0, 0, 0, 0, C_IDLE, 4, 1, 4, 1'b0);

        // Simultaneous hazards, then redirect entry from DSTALL and dh during REDIRECT_WAIT
        rst("reset4");
        v("all_hazards", 0, 1, 1, 1, C_DST, 0, 0, 0, 1'b0);
        v("br_after_dh", 0, 0, 1, 0, C_BR, 1, 0, 1, 1'b0);
        v("idle_a", 0, 0, 0, 0, C_IDLE, 1, 1, 1, 1'b0);
        v("idle_b", 0, 0, 0, 0, C_IDLE, 1, 1, 1, 1'b0);
        v("dh_single", 0, 1, 0, 0, C_DST, 1, 1, 1, 1'b0);
        v("jal_imem_from_dstall", 1, 0, 0, 1, C_IM, 2, 1, 2, 1'b0);
        v("rw_imem", 1, 0, 0, 0, C_RW_IM, 3, 2, 3, 1'b0);
        v("rw_dh", 1, 1, 0, 0, C_RW_DH, 4, 2, 4, 1'b0);
        v("rw_exit", 0, 0, 0, 0, C_RW, 5, 2, 5, 1'b0);
        v("run_again", 0, 0, 0, 0, C_IDLE, 5, 2, 5, 1'b0);

        // Watchdog: 3 dh, gap, 4 dh, sticky, then asynchronous clear
        rst("reset5");
        for (int i = 0; i < 3; i++) v("wd_run1", 0, 1, 0, 0, C_DST, i, 0, i, 1'b0);
        v("wd_gap", 0, 0, 0, 0, C_IDLE, 3, 0, 3, 1'b0);
        for (int i = 3; i < 7; i++) v("wd_run2", 0, 1, 0, 0, C_DST, i, 0, i, 1'b0);
        v("wd_trip", 0, 0, 0, 0, C_IDLE, 7, 0, 7, 1'b1);
        v("wd_sticky", 0, 0, 0, 0, C_IDLE, 7, 0, 7, 1'b1);
        rst("wd_async_clear");

        // Counter saturation on the 3-bit instance
        rst("reset6");
        for (int i = 0; i < 10; i++)
            v("sat_imem", 1, 0, 0, 0, C_IM, i, 0, (i > 7) ? 7 : i, 1'b0);
        v("sat_hold", 0, 0, 0, 0, C_IDLE, 10, 0, 7, 1'b0);

        @(posedge clock);
        #1;
        vld = 1'b0;
        repeat (2) @(negedge clock);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
